// File: rtl/rv32ima_pkg.sv
// Shared RV32IMA pipeline types: redirect FSM states and instruction size.
package rv32ima_pkg;

  localparam int RV_INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } redirect_state_t;

endpackage

// File: rtl/redirect_ctrl_if.sv
// Execute-resolution inputs, fetch redirect handshake and perf counters of redirect_ctrl.
interface redirect_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  import rv32ima_pkg::*;

  logic             ex_valid;
  logic             ex_is_ctrl;
  logic [XLEN-1:0]  ex_pc;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_addr;
  logic             br_next_addr_en;
  logic [XLEN-1:0]  br_next_addr;
  logic             fetch_ready;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_addr;
  logic             flush_fe;
  logic             ex_hold;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output ex_valid, ex_is_ctrl, ex_pc, ex_pred_taken, ex_pred_addr,
           br_next_addr_en, br_next_addr, fetch_ready,
    input  redirect_valid, redirect_addr, flush_fe, ex_hold, branch_cnt, mispred_cnt
  );

  modport slave (
    input  ex_valid, ex_is_ctrl, ex_pc, ex_pred_taken, ex_pred_addr,
           br_next_addr_en, br_next_addr, fetch_ready,
    output redirect_valid, redirect_addr, flush_fe, ex_hold, branch_cnt, mispred_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; count updates one cycle after inc, sticks at all-ones.
// No backpressure: inc is sampled every cycle.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/redirect_ctrl.sv
// Compares resolved vs predicted next PC; mispredict raises a registered redirect next cycle.
// Redirect held until fetch_ready, then DRAIN_CYCLES of flush; ex_hold stalls execute throughout.
module redirect_ctrl
  import rv32ima_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input logic           clk,
  input logic           rst,
  redirect_ctrl_if.slave bus
);

  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  redirect_state_t state;
  logic [XLEN-1:0] redirect_addr_q;
  logic [DW-1:0]   drain_cnt;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] actual_pc;
  logic [XLEN-1:0] pred_pc;
  logic            accept;
  logic            mispredict;

  assign seq_pc     = bus.ex_pc + XLEN'(RV_INSTR_BYTES);
  assign actual_pc  = bus.br_next_addr_en ? bus.br_next_addr : seq_pc;
  assign pred_pc    = bus.ex_pred_taken ? bus.ex_pred_addr : seq_pc;
  assign accept     = bus.ex_valid && bus.ex_is_ctrl && (state == IDLE);
  assign mispredict = accept && (actual_pc != pred_pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      redirect_addr_q <= '0;
      drain_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mispredict) begin
            state           <= REDIRECT;
            redirect_addr_q <= actual_pc;
          end
        end
        REDIRECT: begin
          if (bus.fetch_ready) begin
            if (DRAIN_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DW'(DRAIN_CYCLES);
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - DW'(1);
          if (drain_cnt == DW'(1)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state only, so they appear the cycle after the mispredict.
  assign bus.redirect_valid = (state == REDIRECT);
  assign bus.flush_fe       = (state != IDLE);
  assign bus.ex_hold        = (state != IDLE);
  assign bus.redirect_addr  = redirect_addr_q;

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .count (bus.branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mispredict),
    .count (bus.mispred_cnt)
  );

endmodule

// File: tb/tb_redirect_ctrl.sv
// Bench for redirect_ctrl: directed vector table, hand sequences, and random traffic vs a reference model.
module tb_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_ctrl, ex_pred_taken, br_next_addr_en, fetch_ready;
  logic [31:0] ex_pc, ex_pred_addr, br_next_addr;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Instance 0: default drain of 2, 32-bit counters. Instance 1: no drain, 4-bit counters.
  redirect_ctrl_if #(.XLEN(32), .CNT_W(32)) u_if0 ();
  redirect_ctrl_if #(.XLEN(32), .CNT_W(4))  u_if1 ();

  assign u_if0.ex_valid = ex_valid;         assign u_if1.ex_valid = ex_valid;
  assign u_if0.ex_is_ctrl = ex_is_ctrl;     assign u_if1.ex_is_ctrl = ex_is_ctrl;
  assign u_if0.ex_pc = ex_pc;               assign u_if1.ex_pc = ex_pc;
  assign u_if0.ex_pred_taken = ex_pred_taken; assign u_if1.ex_pred_taken = ex_pred_taken;
  assign u_if0.ex_pred_addr = ex_pred_addr; assign u_if1.ex_pred_addr = ex_pred_addr;
  assign u_if0.br_next_addr_en = br_next_addr_en; assign u_if1.br_next_addr_en = br_next_addr_en;
  assign u_if0.br_next_addr = br_next_addr; assign u_if1.br_next_addr = br_next_addr;
  assign u_if0.fetch_ready = fetch_ready;   assign u_if1.fetch_ready = fetch_ready;

  redirect_ctrl #(.XLEN(32), .DRAIN_CYCLES(2), .CNT_W(32)) u_dut0 (.clk(clk), .rst(rst), .bus(u_if0));
  redirect_ctrl #(.XLEN(32), .DRAIN_CYCLES(0), .CNT_W(4))  u_dut1 (.clk(clk), .rst(rst), .bus(u_if1));

  // Reference model: a redirect is "pending" until handshaken, then a plain count of flush cycles remains.
  bit          m_pend  [2];
  int          m_drain [2];
  logic [31:0] m_addr  [2];
  longint      m_bc    [2];
  longint      m_mc    [2];
  int          m_dcyc  [2] = '{2, 0};
  longint      m_max   [2] = '{64'hFFFF_FFFF, 64'd15};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic model_update(input int i);
    logic [31:0] act_pc, pred_pc;
    if (rst) begin
      m_pend[i] = 0; m_drain[i] = 0; m_addr[i] = '0; m_bc[i] = 0; m_mc[i] = 0;
    end else if (m_pend[i]) begin
      if (fetch_ready) begin
        m_pend[i]  = 0;
        m_drain[i] = m_dcyc[i];
      end
    end else if (m_drain[i] > 0) begin
      m_drain[i]--;
    end else if (ex_valid && ex_is_ctrl) begin
      act_pc  = br_next_addr_en ? br_next_addr : ex_pc + 32'd4;
      pred_pc = ex_pred_taken   ? ex_pred_addr : ex_pc + 32'd4;
      if (m_bc[i] < m_max[i]) m_bc[i]++;
      if (act_pc != pred_pc) begin
        if (m_mc[i] < m_max[i]) m_mc[i]++;
        m_addr[i] = act_pc;
        m_pend[i] = 1;
      end
    end
  endtask

  task automatic check_inst(input int i, input string p, input logic rv, input logic fl, input logic hd,
                            input logic [31:0] addr, input logic [31:0] bc, input logic [31:0] mc);
    logic busy;
    busy = m_pend[i] || (m_drain[i] > 0);
    chk({p, "model_redirect_valid"}, {31'd0, rv}, {31'd0, m_pend[i]});
    chk({p, "model_flush_fe"},       {31'd0, fl}, {31'd0, busy});
    chk({p, "model_ex_hold"},        {31'd0, hd}, {31'd0, busy});
    chk({p, "model_redirect_addr"},  addr, m_addr[i]);
    chk({p, "model_branch_cnt"},     bc, 32'(m_bc[i]));
    chk({p, "model_mispred_cnt"},    mc, 32'(m_mc[i]));
  endtask

  // Inputs change only at negedge; model follows the posedge; outputs checked at the next negedge.
  task automatic tick();
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
    check_inst(0, "dut0_", u_if0.redirect_valid, u_if0.flush_fe, u_if0.ex_hold,
               u_if0.redirect_addr, u_if0.branch_cnt, u_if0.mispred_cnt);
    check_inst(1, "dut1_", u_if1.redirect_valid, u_if1.flush_fe, u_if1.ex_hold,
               u_if1.redirect_addr, {28'd0, u_if1.branch_cnt}, {28'd0, u_if1.mispred_cnt});
  endtask

  task automatic drive(input logic r, input logic ev, input logic [31:0] pc, input logic pt,
                       input logic [31:0] pa, input logic en, input logic [31:0] na, input logic fr);
    rst = r; ex_valid = ev; ex_is_ctrl = 1'b1; ex_pc = pc; ex_pred_taken = pt;
    ex_pred_addr = pa; br_next_addr_en = en; br_next_addr = na; fetch_ready = fr;
  endtask

  typedef struct {
    logic        rst, ev;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] pa;
    logic        en;
    logic [31:0] na;
    logic        fr;
    logic        rv;
    logic [31:0] addr;
    logic        hd;
    logic [31:0] bc, mc;
  } vec_t;

  function automatic vec_t v(input logic r, input logic ev, input logic [31:0] pc, input logic pt,
                             input logic [31:0] pa, input logic en, input logic [31:0] na, input logic fr,
                             input logic rv, input logic [31:0] addr, input logic hd,
                             input logic [31:0] bc, input logic [31:0] mc);
    vec_t t;
    t.rst = r; t.ev = ev; t.pc = pc; t.pt = pt; t.pa = pa; t.en = en; t.na = na; t.fr = fr;
    t.rv = rv; t.addr = addr; t.hd = hd; t.bc = bc; t.mc = mc;
    return t;
  endfunction

  vec_t vecs[$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_drain[i] = 0; m_addr[i] = '0; m_bc[i] = 0; m_mc[i] = 0;
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("reset_redirect_valid", {31'd0, u_if0.redirect_valid}, 32'd0);
    chk("reset_ex_hold", {31'd0, u_if0.ex_hold}, 32'd0);

    // Directed table for instance 0 (drain 2): expected values written out per cycle.
    vecs.push_back(v(0,1,32'h100,0,0,0,0,1,             0,32'h0,0,1,0)); // correct not-taken
    vecs.push_back(v(0,1,32'h100,0,0,1,32'h200,1,       1,32'h200,1,2,1)); // taken mispredict
    vecs.push_back(v(0,1,32'h500,0,0,1,32'h600,1,       0,32'h200,1,2,1));
    vecs.push_back(v(0,1,32'h500,0,0,1,32'h600,1,       0,32'h200,1,2,1));
    vecs.push_back(v(0,1,32'h700,1,32'h800,0,0,1,       0,32'h200,0,2,1)); // return edge: ignored
    vecs.push_back(v(0,1,32'hFFFF_FFFC,1,32'h1000,0,0,0, 1,32'h0,1,3,2)); // wrap-around
    vecs.push_back(v(0,0,0,0,0,0,0,0,                   1,32'h0,1,3,2));
    vecs.push_back(v(0,0,0,0,0,0,0,1,                   0,32'h0,1,3,2));
    vecs.push_back(v(0,0,0,0,0,0,0,1,                   0,32'h0,1,3,2));
    vecs.push_back(v(0,0,0,0,0,0,0,1,                   0,32'h0,0,3,2));
    vecs.push_back(v(0,1,32'h40,1,32'h80,1,32'h80,0,    0,32'h0,0,4,2)); // correct taken
    vecs.push_back(v(0,1,32'h2000,1,32'h300,1,32'h340,0, 1,32'h340,1,5,3)); // target mismatch
    vecs.push_back(v(0,1,32'h2000,1,32'h900,0,0,0,      1,32'h340,1,5,3));
    vecs.push_back(v(0,1,32'h44,0,0,1,32'h48,0,         1,32'h340,1,5,3));
    vecs.push_back(v(0,1,32'h60,1,32'h64,1,32'h99,0,    1,32'h340,1,5,3));
    vecs.push_back(v(0,0,0,0,0,0,0,1,                   0,32'h340,1,5,3));
    vecs.push_back(v(0,0,0,0,0,0,0,1,                   0,32'h340,1,5,3));
    vecs.push_back(v(0,0,0,0,0,0,0,0,                   0,32'h340,0,5,3));
    vecs.push_back(v(0,1,32'h10,0,0,1,32'h20,1,         1,32'h20,1,6,4));
    vecs.push_back(v(0,0,0,0,0,0,0,1,                   0,32'h20,1,6,4));
    vecs.push_back(v(0,0,0,0,0,0,0,1,                   0,32'h20,1,6,4));
    vecs.push_back(v(1,1,32'h10,0,0,1,32'h20,1,         0,32'h0,0,0,0)); // reset in 2nd drain cycle
    vecs.push_back(v(0,1,32'h30,0,0,1,32'h90,1,         1,32'h90,1,1,1)); // first cycle after reset
    vecs.push_back(v(0,0,0,0,0,0,0,1,                   0,32'h90,1,1,1));
    vecs.push_back(v(0,0,0,0,0,0,0,1,                   0,32'h90,1,1,1));
    vecs.push_back(v(0,0,0,0,0,0,0,1,                   0,32'h90,0,1,1));

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].ev, vecs[k].pc, vecs[k].pt, vecs[k].pa, vecs[k].en, vecs[k].na, vecs[k].fr);
      tick();
      chk($sformatf("vec%0d_redirect_valid", k), {31'd0, u_if0.redirect_valid}, {31'd0, vecs[k].rv});
      chk($sformatf("vec%0d_redirect_addr", k), u_if0.redirect_addr, vecs[k].addr);
      chk($sformatf("vec%0d_flush_fe", k), {31'd0, u_if0.flush_fe}, {31'd0, vecs[k].hd});
      chk($sformatf("vec%0d_ex_hold", k), {31'd0, u_if0.ex_hold}, {31'd0, vecs[k].hd});
      chk($sformatf("vec%0d_branch_cnt", k), u_if0.branch_cnt, vecs[k].bc);
      chk($sformatf("vec%0d_mispred_cnt", k), u_if0.mispred_cnt, vecs[k].mc);
    end

    // Zero-drain instance: one-cycle redirect with fetch_ready tied high, then 17 correct branches saturate.
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 1, 32'h100, 0, 0, 1, 32'h200, 1);
    tick();
    chk("d0_redirect_valid", {31'd0, u_if1.redirect_valid}, 32'd1);
    chk("d0_redirect_addr", u_if1.redirect_addr, 32'h200);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("d0_back_idle_hold", {31'd0, u_if1.ex_hold}, 32'd0);
    chk("d0_back_idle_valid", {31'd0, u_if1.redirect_valid}, 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    for (int n = 0; n < 17; n++) begin
      drive(0, 1, 32'h100 + 32'(n * 4), 0, 0, 0, 0, 1);
      tick();
    end
    chk("sat_branch_cnt", {28'd0, u_if1.branch_cnt}, 32'd15);
    chk("sat_mispred_cnt", {28'd0, u_if1.mispred_cnt}, 32'd0);
    chk("sat_no_hold", {31'd0, u_if1.ex_hold}, 32'd0);

    // Random traffic, checked every cycle against the model for both instances.
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] pc, pa, na;
      pc = {$urandom_range(0, 255), 2'b00};
      if (n % 300 == 0) pc = 32'hFFFF_FFFC;
      pa = ($urandom_range(0, 1) == 1) ? pc + 32'h40 : {$urandom_range(0, 255), 2'b00};
      na = ($urandom_range(0, 2) != 0) ? pa : {$urandom_range(0, 255), 2'b00};
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 1)),
            pa, 1'($urandom_range(0, 1)), na, ($urandom_range(0, 9) < 6));
      ex_is_ctrl = ($urandom_range(0, 4) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Sequences control-flow redirects for the RV32IMA pipeline. It compares the branch/jump outcome resolved in execute against the front-end prediction that travelled with the instruction. On a mispredict it holds a redirect request to fetch until accepted, squashes wrong-path front-end state, and drains a fixed number of stale in-flight fetch responses. It also keeps saturating branch/mispredict counters.

## Interface
Parameters:
- XLEN, 32, address width
- DRAIN_CYCLES, 2, stale fetch responses to drop after redirect accept (0 allowed)
- CNT_W, 32, performance counter width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  reset
- ex_valid  in  1  execute-stage instruction valid this cycle
- ex_is_ctrl  in  1  instruction is a branch or jump
- ex_pc  in  XLEN  PC of execute instruction
- ex_pred_taken  in  1  front end predicted taken
- ex_pred_addr  in  XLEN  predicted target (meaningful only when ex_pred_taken)
- br_next_addr_en  in  1  resolver: control transfer taken
- br_next_addr  in  XLEN  resolver: taken target
- fetch_ready  in  1  fetch accepts redirect this cycle
- redirect_valid  out  1  redirect request to fetch
- redirect_addr  out  XLEN  redirect PC
- flush_fe  out  1  squash IF/ID registers and drop fetch responses
- ex_hold  out  1  stall execute and downstream issue
- branch_cnt  out  CNT_W  resolved control instructions
- mispred_cnt  out  CNT_W  mispredicts

## Operation
- Accepted resolution: ex_valid && ex_is_ctrl && state==IDLE.
- Actual next PC: br_next_addr_en ? br_next_addr : ex_pc+4. Predicted next PC: ex_pred_taken ? ex_pred_addr : ex_pc+4. The +4 is modulo 2^XLEN.
- Mispredict: accepted resolution with actual != predicted.
- States:
  - IDLE: all outputs low. On mispredict, latch actual PC into redirect_addr and go to REDIRECT.
  - REDIRECT: redirect_valid=1, flush_fe=1, ex_hold=1. On fetch_ready, go to DRAIN with drain_cnt=DRAIN_CYCLES, or to IDLE if DRAIN_CYCLES==0.
  - DRAIN: flush_fe=1, ex_hold=1, redirect_valid=0. drain_cnt decrements each cycle; when it reaches 1, return to IDLE on the next edge.
- Inputs on ex_* are ignored outside IDLE. ex_hold guarantees the instruction is not re-presented.
- redirect_addr stays stable while redirect_valid=1. It holds its last value otherwise.
- branch_cnt increments on every accepted resolution. mispred_cnt increments on every mispredict. Both saturate at all-ones.
- Correctly predicted resolutions cause no output change other than branch_cnt.

## Timing
- Reset: state=IDLE, redirect_valid=0, redirect_addr=0, flush_fe=0, ex_hold=0, drain_cnt=0, both counters 0. Reset mid-REDIRECT or mid-DRAIN abandons the redirect immediately, with no handshake. rst has priority over all other inputs.
- Mispredict at edge N: redirect_valid, flush_fe and ex_hold are high from cycle N+1 (registered outputs). Counters update at edge N.
- Handshake: the transfer occurs on the cycle where redirect_valid && fetch_ready. fetch_ready while redirect_valid=0 has no effect. fetch_ready may be held high permanently, giving the minimum redirect of 1 cycle.
- Minimum penalty: 1 + DRAIN_CYCLES cycles of ex_hold.
- A mispredict cannot be accepted in the same cycle the FSM returns to IDLE. The earliest next acceptance is the first IDLE cycle.

## Structure
- rv32ima_pkg gains redirect_state_t (IDLE, REDIRECT, DRAIN) and a RV_INSTR_BYTES=4 constant.
- One sub-module, sat_counter (parameter W; inputs clk, rst, inc; output count), instantiated for branch_cnt and mispred_cnt.
- Comparison and next-PC logic stay combinational in the top level. The FSM, redirect_addr and drain_cnt are registered.

## Test plan
- Correct not-taken: ex_pc=0x100, pred_taken=0, br_next_addr_en=0 -> no redirect; branch_cnt=1, mispred_cnt=0.
- Taken mispredict, fetch_ready tied 1, DRAIN_CYCLES=2: ex_pc=0x100, pred_taken=0, br_next_addr=0x200 -> redirect_valid and redirect_addr=0x200 in cycle N+1 only; flush_fe/ex_hold high for cycles N+1..N+3; IDLE at N+4; mispred_cnt=1.
- Target mismatch with fetch_ready low for 3 cycles: pred 0x300, actual 0x340 -> redirect_valid and redirect_addr=0x340 held stable for 4 cycles; ex_* changes during hold are ignored and branch_cnt does not change.
- Predicted taken, actually not taken: ex_pc=0xFFFFFFFC, pred_taken=1 -> redirect_addr=0x00000000 (wrap-around).
- Reset asserted in the second DRAIN cycle -> all outputs 0 on the next cycle, counters 0, and a new mispredict is accepted on the first cycle after rst deasserts.
- Saturation with CNT_W=4: 17 correct branches -> branch_cnt=15.
